key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Conditions the DE2 active-low pushbuttons before they reach register-load and control logic.
- Synchronises each raw KEY input to CLOCK_50, filters contact bounce with a per-key stability counter, and produces a clean pressed level plus single-cycle press and release strobes.
- Downstream logic uses press_pulse in place of asynchronous KEY edges, for example as the load enable of the displayed 16-bit value register.

Parameters:
- N_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYC, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range is 2 or more.
- REPEAT_DELAY_CYC, 25000000, hold time before the first auto-repeat strobe; used only with KEY_AUTOREPEAT_EN.
- REPEAT_RATE_CYC, 5000000, interval between subsequent auto-repeat strobes; used only with KEY_AUTOREPEAT_EN.
- CW, $clog2(max of all three counts)+1, counter width (derived; not overridden).

Ports:
- CLOCK_50 in 1 system clock, 50 MHz.
- RESET_N in 1 synchronous active-low reset.
- KEY in N_KEYS raw pushbuttons, active-low (0 = pressed), asynchronous.
- key_down out N_KEYS debounced level, active-high (1 = pressed).
- press_pulse out N_KEYS one-cycle strobe on accepted press (and on repeats, if enabled).
- release_pulse out N_KEYS one-cycle strobe on accepted release.

Behaviour:
- Everything updates on the rising edge of CLOCK_50; there are no other clocks and no async logic.
- Reset (RESET_N=0 at a clock edge):
  - sync flops = 1 (released).
  - Per-key state = RELEASED, counters = 0.
  - key_down = 0, press_pulse = 0, release_pulse = 0.
- Synchroniser: two flops per key, sync2 = KEY delayed 2 cycles, inverted internally to pressed = ~sync2.
- Per-key FSM, each key independent:
  - RELEASED: if pressed, go to PRESS_PEND with cnt=1; else cnt=0.
  - PRESS_PEND: if !pressed, go to RELEASED with cnt=0 (bounce discards progress). Else if cnt==DEBOUNCE_CYC-1, go to PRESSED, key_down<=1, press_pulse<=1. Else cnt++.
  - PRESSED: mirror of RELEASED; if !pressed, go to REL_PEND with cnt=1.
  - REL_PEND: if pressed, go to PRESSED. Else if cnt==DEBOUNCE_CYC-1, go to RELEASED, key_down<=0, release_pulse<=1. Else cnt++.
- Latency: a KEY level first sampled at edge E0 and held steady gives key_down changing, and its pulse asserting, at edge E0+DEBOUNCE_CYC+1.
- Pulses are registered, high for exactly one cycle, then forced back to 0.
- press_pulse and release_pulse are never high together on the same key.
- Any bounce shorter than DEBOUNCE_CYC cycles produces no output change.
- Simultaneous activity on multiple keys is fully independent; several bits may pulse in the same cycle.
- Key held through reset: after RESET_N rises, the key is accepted as a fresh press (press_pulse fires after the normal latency).
- Reset asserted mid-debounce or mid-press: all progress is discarded; no pulse is generated by the reset itself.
- Counters saturate by construction; they never wrap.

Optional Feature:
- Macro: KEY_AUTOREPEAT_EN.
- Defined:
  - Each key has a repeat counter, cleared on entry to PRESSED.
  - While in PRESSED (including REL_PEND does not count), after REPEAT_DELAY_CYC cycles, press_pulse fires again for 1 cycle.
  - Thereafter it fires every REPEAT_RATE_CYC cycles until the key leaves PRESSED.
  - Entering REL_PEND and returning to PRESSED restarts the delay.
  - key_down is unaffected.
- Undefined: repeat logic is absent; press_pulse fires only once per accepted press.

Test Plan:
- DEBOUNCE_CYC=4, reset, KEY=4'hF steady for 20 cycles -> key_down=0 and no pulses at any time.
- KEY[3] driven 0 at edge 10 and held -> key_down[3]=1 from edge 15, press_pulse[3]=1 only in cycle 15–16, other bits 0.
- KEY[0] bounces 0,1,0,1,0 with 2-cycle widths, then holds 0 -> exactly one press_pulse[0], 5 cycles after the final steady 0 sample; no release_pulse.
- KEY[1] and KEY[2] released in the same cycle after being pressed -> release_pulse=4'b0110 in a single cycle, key_down bits 1 and 2 cleared together.
- KEY[3] held low across a 3-cycle RESET_N pulse mid-PRESS_PEND -> outputs 0 during reset; press_pulse[3] at release-of-reset edge + DEBOUNCE_CYC+1.
- KEY_AUTOREPEAT_EN defined, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3, KEY[2] held 25 cycles past acceptance -> press_pulse[2] at acceptance, +10, +13, +16, +19, +22, +25; none after release.

Source files
------------

// File: rtl/key_debounce_if.sv
// Key conditioner bundle: raw active-low KEY in, debounced level and strobes out.
interface key_debounce_if #(
  parameter int unsigned N_KEYS = 4
);
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] key_down;
  logic [N_KEYS-1:0] press_pulse;
  logic [N_KEYS-1:0] release_pulse;

  modport master (
    output KEY,
    input  key_down,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  KEY,
    output key_down,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/key_debounce.sv
// Per-key synchroniser, debounce FSM and press/release strobes for DE2 pushbuttons.
// Optional auto-repeat of press_pulse while held: define KEY_AUTOREPEAT_EN.
module key_debounce #(
  parameter int unsigned N_KEYS           = 4,
  parameter int unsigned DEBOUNCE_CYC     = 500000,
  parameter int unsigned REPEAT_DELAY_CYC = 25000000,
  parameter int unsigned REPEAT_RATE_CYC  = 5000000
) (
  input logic           CLOCK_50,
  input logic           RESET_N,
  key_debounce_if.slave kif
);

  localparam int unsigned MAX_AB = (DEBOUNCE_CYC > REPEAT_DELAY_CYC) ? DEBOUNCE_CYC : REPEAT_DELAY_CYC;
  localparam int unsigned MAX_C  = (MAX_AB > REPEAT_RATE_CYC) ? MAX_AB : REPEAT_RATE_CYC;
  localparam int unsigned CW     = $clog2(MAX_C) + 1;

  localparam logic [1:0] ST_RELEASED   = 2'd0;
  localparam logic [1:0] ST_PRESS_PEND = 2'd1;
  localparam logic [1:0] ST_PRESSED    = 2'd2;
  localparam logic [1:0] ST_REL_PEND   = 2'd3;

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] pressed;

  logic [1:0]        state [N_KEYS];
  logic [CW-1:0]     cnt   [N_KEYS];
  logic [N_KEYS-1:0] down_q;
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] rel_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CW-1:0] RPT_DELAY_LAST = CW'(REPEAT_DELAY_CYC - 1);
  localparam logic [CW-1:0] RPT_RATE_LAST  = CW'(REPEAT_RATE_CYC - 1);

  logic [CW-1:0]     rpt_cnt [N_KEYS];
  logic [N_KEYS-1:0] rpt_phase;
`endif

  // Reset value 1 matches a released (active-low) key
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= kif.KEY;
      sync2 <= sync1;
    end
  end

  assign pressed = ~sync2;

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        state[i] <= ST_RELEASED;
        cnt[i]   <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rpt_cnt[i] <= '0;
`endif
      end
`ifdef KEY_AUTOREPEAT_EN
      rpt_phase <= '0;
`endif
      down_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      // Strobes default low; a key event below overrides its own bit
      press_q <= '0;
      rel_q   <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        case (state[i])
          ST_RELEASED: begin
            if (pressed[i]) begin
              state[i] <= ST_PRESS_PEND;
              cnt[i]   <= CW'(1);
            end else begin
              cnt[i] <= '0;
            end
          end
          ST_PRESS_PEND: begin
            if (!pressed[i]) begin
              state[i] <= ST_RELEASED;
              cnt[i]   <= '0;
            end else if (cnt[i] == DB_LAST) begin
              state[i]   <= ST_PRESSED;
              cnt[i]     <= '0;
              down_q[i]  <= 1'b1;
              press_q[i] <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
              rpt_cnt[i]   <= '0;
              rpt_phase[i] <= 1'b0;
`endif
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          ST_PRESSED: begin
            if (!pressed[i]) begin
              state[i] <= ST_REL_PEND;
              cnt[i]   <= CW'(1);
            end else begin
              cnt[i] <= '0;
`ifdef KEY_AUTOREPEAT_EN
              // First interval uses the delay, later ones the rate
              if (rpt_cnt[i] == (rpt_phase[i] ? RPT_RATE_LAST : RPT_DELAY_LAST)) begin
                press_q[i]   <= 1'b1;
                rpt_cnt[i]   <= '0;
                rpt_phase[i] <= 1'b1;
              end else begin
                rpt_cnt[i] <= rpt_cnt[i] + CW'(1);
              end
`endif
            end
          end
          ST_REL_PEND: begin
            if (pressed[i]) begin
              state[i] <= ST_PRESSED;
              cnt[i]   <= '0;
`ifdef KEY_AUTOREPEAT_EN
              rpt_cnt[i]   <= '0;
              rpt_phase[i] <= 1'b0;
`endif
            end else if (cnt[i] == DB_LAST) begin
              state[i]  <= ST_RELEASED;
              cnt[i]    <= '0;
              down_q[i] <= 1'b0;
              rel_q[i]  <= 1'b1;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: begin
            state[i] <= ST_RELEASED;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign kif.key_down      = down_q;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = rel_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: expected strobe events are queued as keys are
// driven and matched against every nonzero strobe cycle the DUT produces.
module tb_key_debounce;

  localparam int unsigned NK  = 4;
  localparam int unsigned DB  = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RR  = 3;
  localparam int          LAT = DB + 1;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b0;
  int   tests    = 0;
  int   fails    = 0;
  int   edge_n   = 0;

  typedef struct {
    int         e;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] d;
  } ev_t;

  ev_t sb[$];

  key_debounce_if #(.N_KEYS(NK)) kif ();

  key_debounce #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYC    (DB),
    .REPEAT_DELAY_CYC(RD),
    .REPEAT_RATE_CYC (RR)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .kif     (kif)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int e, input logic [3:0] p, input logic [3:0] r, input logic [3:0] d);
    ev_t ev;
    ev.e = e;
    ev.p = p;
    ev.r = r;
    ev.d = d;
    sb.push_back(ev);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // Any strobe cycle must match the oldest queued event exactly
  always @(posedge CLOCK_50) begin
    ev_t ev;
    edge_n++;
    #2;
    if ((kif.press_pulse | kif.release_pulse) !== 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {24'd0, kif.press_pulse, kif.release_pulse}, 32'd0);
      end else begin
        ev = sb.pop_front();
        check("pulse_edge", edge_n, ev.e);
        check("press_pulse", {28'd0, kif.press_pulse}, {28'd0, ev.p});
        check("release_pulse", {28'd0, kif.release_pulse}, {28'd0, ev.r});
        check("key_down_at_pulse", {28'd0, kif.key_down}, {28'd0, ev.d});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    kif.KEY = 4'hF;
    RESET_N = 1'b0;
    tick(3);
    check("rst_key_down", {28'd0, kif.key_down}, 32'd0);
    check("rst_press", {28'd0, kif.press_pulse}, 32'd0);
    check("rst_release", {28'd0, kif.release_pulse}, 32'd0);
    RESET_N = 1'b1;
    tick(20);
    check("idle_key_down", {28'd0, kif.key_down}, 32'd0);

    // Single key press: level changes exactly LAT edges after first sample
    kif.KEY = 4'b0111;
    a = edge_n + 1 + LAT;
    push(a, 4'b1000, 4'b0000, 4'b1000);
    tick(LAT);
    check("k3_down_early", {28'd0, kif.key_down}, 32'd0);
    tick(1);
    check("k3_down", {28'd0, kif.key_down}, 32'h8);
    kif.KEY = 4'hF;
    push(edge_n + 1 + LAT, 4'b0000, 4'b1000, 4'b0000);
    tick(10);
    check("k3_released", {28'd0, kif.key_down}, 32'd0);

    // Bouncing key0, two-cycle widths, then steady low
    for (int i = 0; i < 4; i++) begin
      kif.KEY[0] = 1'(i % 2);
      tick(2);
    end
    kif.KEY[0] = 1'b0;
    push(edge_n + 1 + LAT, 4'b0001, 4'b0000, 4'b0001);
    tick(LAT + 1);
    check("k0_down", {28'd0, kif.key_down}, 32'h1);
    kif.KEY = 4'hF;
    push(edge_n + 1 + LAT, 4'b0000, 4'b0001, 4'b0000);
    tick(10);

    // Keys 1 and 2 together
    kif.KEY = 4'b1001;
    push(edge_n + 1 + LAT, 4'b0110, 4'b0000, 4'b0110);
    tick(LAT + 1);
    check("k12_down", {28'd0, kif.key_down}, 32'h6);
    kif.KEY = 4'hF;
    push(edge_n + 1 + LAT, 4'b0000, 4'b0110, 4'b0000);
    tick(10);
    check("k12_released", {28'd0, kif.key_down}, 32'd0);

    // Low for exactly DB cycles is accepted; DB-1 is not
    a = edge_n;
    kif.KEY = 4'b1101;
    push(a + 1 + LAT, 4'b0010, 4'b0000, 4'b0010);
    push(a + 1 + DB + LAT, 4'b0000, 4'b0010, 4'b0000);
    tick(DB);
    kif.KEY = 4'hF;
    tick(10);
    kif.KEY = 4'b1101;
    tick(DB - 1);
    kif.KEY = 4'hF;
    tick(10);
    check("short_low_ignored", {28'd0, kif.key_down}, 32'd0);

    // Release glitch of DB-1 cycles on a held key is ignored
    kif.KEY = 4'b0111;
    push(edge_n + 1 + LAT, 4'b1000, 4'b0000, 4'b1000);
    tick(LAT + 1);
    kif.KEY = 4'hF;
    tick(DB - 1);
    kif.KEY = 4'b0111;
    tick(2);
    check("glitch_held", {28'd0, kif.key_down}, 32'h8);
    kif.KEY = 4'hF;
    push(edge_n + 1 + LAT, 4'b0000, 4'b1000, 4'b0000);
    tick(10);

    // Reset during PRESS_PEND: progress dropped, fresh press after reset
    kif.KEY = 4'b0111;
    tick(3);
    RESET_N = 1'b0;
    tick(3);
    check("midrst_key_down", {28'd0, kif.key_down}, 32'd0);
    check("midrst_press", {28'd0, kif.press_pulse}, 32'd0);
    RESET_N = 1'b1;
    push(edge_n + 1 + LAT, 4'b1000, 4'b0000, 4'b1000);
    tick(LAT + 1);
    check("postrst_down", {28'd0, kif.key_down}, 32'h8);

    // Reset while pressed and key released during reset: no release strobe
    kif.KEY = 4'hF;
    RESET_N = 1'b0;
    tick(3);
    check("rst_pressed_down", {28'd0, kif.key_down}, 32'd0);
    RESET_N = 1'b1;
    tick(10);

    // Long hold on key2 (repeats only with auto-repeat)
    kif.KEY = 4'b1011;
    a = edge_n + 1 + LAT;
    push(a, 4'b0100, 4'b0000, 4'b0100);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = RD; k <= 25; k += RR) push(a + k, 4'b0100, 4'b0000, 4'b0100);
`endif
    tick(LAT + 1);
    tick(25);
    check("k2_held", {28'd0, kif.key_down}, 32'h4);
    kif.KEY = 4'hF;
    push(edge_n + 1 + LAT, 4'b0000, 4'b0100, 4'b0000);
    tick(15);

    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
